serial_word_feeder: RTL and testbench
=====================================

Name: serial_word_feeder

Overview:
- Upstream stage of the bit-serial two's-complement inverter.
- Accepts parallel words over a valid/ready handshake and shifts each word out LSB-first, one bit per clock, onto the inverter's serial input.
- Emits a first-bit strobe that drives the inverter's per-word state clear, plus a last-bit flag so downstream logic can frame words.
- Supports back-to-back words with no idle bubble.

Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), width of the internal bit counter.

Ports:
- t_clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din holds a word.
- din_ready  output  1  feeder can accept a word this cycle.
- ser_bit  output  1  serial data, LSB first; connects to the inverter data input.
- ser_valid  output  1  ser_bit carries a word bit.
- ser_first  output  1  high with bit 0 of every word; drives the inverter's clear input.
- ser_last  output  1  high with bit WIDTH-1 of every word.
- busy  output  1  word in flight (state SHIFT).

Behaviour:
- Reset: one clock domain (t_clk); rst_n asserted low clears everything immediately, without waiting for a clock edge.
  - Register reset values: ser_bit=0, ser_valid=0, ser_first=0, ser_last=0, busy=0, state=IDLE, counter=0, shift register=0.
  - Reset mid-word discards the word with no partial completion. Deasserting rst_n resumes at IDLE.
- States: IDLE and SHIFT.
- Handshake:
  - A transfer occurs on a rising edge where din_valid && din_ready.
  - din_ready = (state==IDLE) || (state==SHIFT && counter==WIDTH-1). It is combinational from registered state, so it reads 1 in IDLE, including during reset.
  - din must be held stable while din_valid=1 and din_ready=0; the feeder samples din only on a transfer edge.
- IDLE:
  - Outputs ser_valid=0, ser_first=0, ser_last=0, ser_bit=0.
  - On a transfer edge: shift register<=din, counter<=0, state<=SHIFT.
- SHIFT:
  - Output timing, per accepted word: word accepted at edge k; bit 0 is valid in the cycle after edge k; bit n is valid in the cycle after edge k+n; bit WIDTH-1 ends at edge k+WIDTH.
  - Outputs are registered, so latency from transfer edge to bit 0 is exactly 1 cycle.
  - Each edge: shift register >> 1, counter+1.
  - ser_first=1 only while counter==0. ser_last=1 only while counter==WIDTH-1. ser_valid=1 for all WIDTH cycles.
- Word end (counter==WIDTH-1):
  - With a transfer on that edge: load the new word, counter<=0, stay in SHIFT. The next cycle is bit 0 of the new word with ser_first=1, so there is no gap between words.
  - Without a transfer: state<=IDLE, counter<=0, all serial outputs return to 0.
- Counter wraps only through reload; it never exceeds WIDTH-1.
- busy = (state==SHIFT), registered.
- din_valid toggling while SHIFT and counter<WIDTH-1 has no effect.

Optional Feature:
- Macro: SER_STALL_EN.
- Defined:
  - Adds input ser_stall (1 bit).
  - While ser_stall=1 in SHIFT: shift register, counter, state and all ser_* outputs hold their values, and din_ready=0 even at counter==WIDTH-1.
  - Stall in IDLE has no effect; din_ready stays 1.
  - A held bit stays valid, so downstream must also gate its own clock enable.
- Undefined: no ser_stall port; the feeder shifts every cycle as above.

Test Plan:
- Reset then single word (WIDTH=8): din=8'h2C with valid for one cycle.
  - ser_bit sequence 0,0,1,1,0,1,0,0 over 8 cycles, starting 1 cycle after accept.
  - ser_first high on the 1st bit only; ser_last on the 8th bit only.
  - Then IDLE, ser_valid=0.
- Back-to-back: din=8'h01, then 8'hFF presented with valid held through the first word.
  - 16 contiguous ser_valid cycles: bits 1,0,0,0,0,0,0,0,1,1,1,1,1,1,1,1.
  - ser_first at cycles 1 and 9.
  - din_ready high only in cycle 8 of the first word.
- Backpressure: din_valid=1 with din=8'hA5 during cycles 2..7 of a word in flight.
  - No transfer until the last-bit cycle.
  - din_ready=0 for those cycles; 8'hA5 is serialized as 1,0,1,0,0,1,0,1 after the current word.
- Reset mid-word: assert rst_n=0 at bit 3 of 8'h5A, asynchronously between edges.
  - All ser_* outputs and busy drop immediately.
  - After release: IDLE, din_ready=1; the next word 8'h03 serializes correctly with ser_first on bit 0.
- SER_STALL_EN: stall 3 cycles at bit 2 of 8'h2C.
  - ser_bit holds 1 for 4 cycles total, and the counter holds.
  - The remaining bits follow unchanged; ser_last arrives 3 cycles late.
- WIDTH=2 boundary: din=2'b10, then 2'b01 back-to-back.
  - Output 0,1,1,0.
  - ser_first and ser_last alternate every cycle.

Source files
------------

// File: rtl/serial_word_feeder_if.sv
// Word-in / bit-out bundle of the serial word feeder.
// With SER_STALL_EN defined the bundle also carries the downstream ser_stall request.
interface serial_word_feeder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             ser_bit;
  logic             ser_valid;
  logic             ser_first;
  logic             ser_last;
  logic             busy;
`ifdef SER_STALL_EN
  logic             ser_stall;

  modport master (
    output din, din_valid, ser_stall,
    input  din_ready, ser_bit, ser_valid, ser_first, ser_last, busy
  );

  modport slave (
    input  din, din_valid, ser_stall,
    output din_ready, ser_bit, ser_valid, ser_first, ser_last, busy
  );
`else
  modport master (
    output din, din_valid,
    input  din_ready, ser_bit, ser_valid, ser_first, ser_last, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, ser_bit, ser_valid, ser_first, ser_last, busy
  );
`endif
endinterface

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder for the bit-serial inverter: LSB first, first/last strobes, no gap between words.
// Optional SER_STALL_EN adds a ser_stall input that freezes the word in flight.
module serial_word_feeder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input logic                 t_clk,
  input logic                 rst_n,
  serial_word_feeder_if.slave bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [WIDTH-1:0] sreg, nxt_sreg;
  logic             ser_bit_q, ser_valid_q, ser_first_q, ser_last_q, busy_q;
  logic             nxt_bit, nxt_valid, nxt_first, nxt_last, nxt_busy;
  logic             stall, xfer;

  always_comb begin
    stall = 1'b0;
`ifdef SER_STALL_EN
    stall = bus.ser_stall && (state == SHIFT);
`endif
  end

  // Ready in IDLE, and on the last bit so the next word follows without a bubble.
  assign bus.din_ready = (state == IDLE) || ((state == SHIFT) && (cnt == LAST) && !stall);
  assign xfer          = bus.din_valid && bus.din_ready;

  always_ff @(posedge t_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      sreg        <= '0;
      ser_bit_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_first_q <= 1'b0;
      ser_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= nxt_state;
      cnt         <= nxt_cnt;
      sreg        <= nxt_sreg;
      ser_bit_q   <= nxt_bit;
      ser_valid_q <= nxt_valid;
      ser_first_q <= nxt_first;
      ser_last_q  <= nxt_last;
      busy_q      <= nxt_busy;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_sreg  = sreg;
    unique case (state)
      IDLE: begin
        if (xfer) begin
          nxt_state = SHIFT;
          nxt_cnt   = '0;
          nxt_sreg  = bus.din;
        end
      end
      SHIFT: begin
        if (stall) begin
          nxt_state = SHIFT;
        end else if (cnt == LAST) begin
          nxt_cnt = '0;
          if (xfer) begin
            nxt_sreg = bus.din;
          end else begin
            nxt_state = IDLE;
          end
        end else begin
          nxt_cnt  = cnt + CNT_W'(1);
          nxt_sreg = sreg >> 1;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Output registers are loaded from the upcoming state, so bit 0 appears one cycle after the transfer.
  always_comb begin
    nxt_valid = 1'b0;
    nxt_bit   = 1'b0;
    nxt_first = 1'b0;
    nxt_last  = 1'b0;
    nxt_busy  = 1'b0;
    if (nxt_state == SHIFT) begin
      nxt_valid = 1'b1;
      nxt_busy  = 1'b1;
      nxt_bit   = nxt_sreg[0];
      nxt_first = (nxt_cnt == '0);
      nxt_last  = (nxt_cnt == LAST);
    end
  end

  assign bus.ser_bit   = ser_bit_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.ser_first = ser_first_q;
  assign bus.ser_last  = ser_last_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Directed self-checking bench for serial_word_feeder (WIDTH=8 and WIDTH=2 instances).
// Stall steps are compiled in when SER_STALL_EN is defined.
module tb_serial_word_feeder;

  logic t_clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  serial_word_feeder_if #(.WIDTH(8)) if8();
  serial_word_feeder_if #(.WIDTH(2)) if2();

  serial_word_feeder #(.WIDTH(8)) dut8 (.t_clk(t_clk), .rst_n(rst_n), .bus(if8));
  serial_word_feeder #(.WIDTH(2)) dut2 (.t_clk(t_clk), .rst_n(rst_n), .bus(if2));

  always #5 t_clk = ~t_clk;

  task automatic step();
    @(posedge t_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] w);
    if8.din       = w;
    if8.din_valid = 1'b1;
    step();
    if8.din_valid = 1'b0;
  endtask

  task automatic checkIdle8(input string tag);
    checkOutput({tag, ".valid"}, 32'(if8.ser_valid), 32'd0);
    checkOutput({tag, ".bit"},   32'(if8.ser_bit),   32'd0);
    checkOutput({tag, ".first"}, 32'(if8.ser_first), 32'd0);
    checkOutput({tag, ".last"},  32'(if8.ser_last),  32'd0);
    checkOutput({tag, ".busy"},  32'(if8.busy),      32'd0);
    checkOutput({tag, ".ready"}, 32'(if8.din_ready), 32'd1);
  endtask

  // Walks all 8 bits of word w; optionally presents the next word from bit index present_at.
  task automatic checkWord(input string tag, input logic [7:0] w, input int present_at,
                           input logic [7:0] nxt);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("%s.bit%0d", tag, i),   32'(if8.ser_bit),   32'(w[i]));
      checkOutput($sformatf("%s.valid%0d", tag, i), 32'(if8.ser_valid), 32'd1);
      checkOutput($sformatf("%s.first%0d", tag, i), 32'(if8.ser_first), 32'(i == 0));
      checkOutput($sformatf("%s.last%0d", tag, i),  32'(if8.ser_last),  32'(i == 7));
      checkOutput($sformatf("%s.busy%0d", tag, i),  32'(if8.busy),      32'd1);
      checkOutput($sformatf("%s.ready%0d", tag, i), 32'(if8.din_ready), 32'(i == 7));
      if (i == present_at) begin
        if8.din       = nxt;
        if8.din_valid = 1'b1;
      end
      step();
    end
  endtask

  initial begin
    if8.din       = '0;
    if8.din_valid = 1'b0;
    if2.din       = '0;
    if2.din_valid = 1'b0;
`ifdef SER_STALL_EN
    if8.ser_stall = 1'b0;
    if2.ser_stall = 1'b0;
`endif
    #1;
    checkIdle8("reset");
    checkOutput("reset.ready2", 32'(if2.din_ready), 32'd1);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    checkIdle8("post_reset");

    $display("[TB] single word 8'h2C");
    applyStimulus(8'h2C);
    checkWord("w2C", 8'h2C, -1, 8'h00);
    checkIdle8("after_2C");

    $display("[TB] back-to-back 8'h01 then 8'hFF");
    applyStimulus(8'h01);
    checkWord("w01", 8'h01, 0, 8'hFF);
    if8.din_valid = 1'b0;
    checkWord("wFF", 8'hFF, -1, 8'h00);
    checkIdle8("after_FF");

    $display("[TB] backpressure 8'h3C then 8'hA5");
    applyStimulus(8'h3C);
    checkWord("w3C", 8'h3C, 1, 8'hA5);
    if8.din_valid = 1'b0;
    checkWord("wA5", 8'hA5, -1, 8'h00);
    checkIdle8("after_A5");

    $display("[TB] reset mid-word 8'h5A");
    applyStimulus(8'h5A);
    repeat (3) step();
    checkOutput("rst_mid.bit3", 32'(if8.ser_bit), 32'd1);
    checkOutput("rst_mid.busy_before", 32'(if8.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkIdle8("rst_async");
    step();
    #2;
    rst_n = 1'b1;
    step();
    checkIdle8("rst_release");
    applyStimulus(8'h03);
    checkWord("w03", 8'h03, -1, 8'h00);
    checkIdle8("after_03");

`ifdef SER_STALL_EN
    $display("[TB] stall 3 cycles at bit 2 of 8'h2C");
    if8.ser_stall = 1'b1;
    checkOutput("stall_idle.ready", 32'(if8.din_ready), 32'd1);
    applyStimulus(8'h2C);
    checkOutput("stall_idle.accepted", 32'(if8.ser_first), 32'd1);
    if8.ser_stall = 1'b0;
    step();
    step();
    checkOutput("stall.bit2", 32'(if8.ser_bit), 32'd1);
    if8.ser_stall = 1'b1;
    if8.din       = 8'hFF;
    if8.din_valid = 1'b1;
    for (int s = 0; s < 3; s++) begin
      step();
      checkOutput($sformatf("stall.hold_bit%0d", s),   32'(if8.ser_bit),   32'd1);
      checkOutput($sformatf("stall.hold_valid%0d", s), 32'(if8.ser_valid), 32'd1);
      checkOutput($sformatf("stall.hold_last%0d", s),  32'(if8.ser_last),  32'd0);
      checkOutput($sformatf("stall.hold_ready%0d", s), 32'(if8.din_ready), 32'd0);
    end
    if8.din_valid = 1'b0;
    if8.ser_stall = 1'b0;
    for (int i = 3; i < 8; i++) begin
      step();
      checkOutput($sformatf("stall.bit%0d", i),  32'(if8.ser_bit),  32'((8'h2C >> i) & 8'h01));
      checkOutput($sformatf("stall.last%0d", i), 32'(if8.ser_last), 32'(i == 7));
    end
    step();
    checkIdle8("after_stall");
`endif

    $display("[TB] WIDTH=2 back-to-back 2'b10 then 2'b01");
    if2.din       = 2'b10;
    if2.din_valid = 1'b1;
    step();
    if2.din       = 2'b01;
    checkOutput("w2.c1.bit",   32'(if2.ser_bit),   32'd0);
    checkOutput("w2.c1.first", 32'(if2.ser_first), 32'd1);
    checkOutput("w2.c1.last",  32'(if2.ser_last),  32'd0);
    checkOutput("w2.c1.ready", 32'(if2.din_ready), 32'd0);
    step();
    checkOutput("w2.c2.bit",   32'(if2.ser_bit),   32'd1);
    checkOutput("w2.c2.first", 32'(if2.ser_first), 32'd0);
    checkOutput("w2.c2.last",  32'(if2.ser_last),  32'd1);
    checkOutput("w2.c2.ready", 32'(if2.din_ready), 32'd1);
    step();
    if2.din_valid = 1'b0;
    checkOutput("w2.c3.bit",   32'(if2.ser_bit),   32'd1);
    checkOutput("w2.c3.first", 32'(if2.ser_first), 32'd1);
    checkOutput("w2.c3.last",  32'(if2.ser_last),  32'd0);
    step();
    checkOutput("w2.c4.bit",   32'(if2.ser_bit),   32'd0);
    checkOutput("w2.c4.first", 32'(if2.ser_first), 32'd0);
    checkOutput("w2.c4.last",  32'(if2.ser_last),  32'd1);
    step();
    checkOutput("w2.idle.valid", 32'(if2.ser_valid), 32'd0);
    checkOutput("w2.idle.busy",  32'(if2.busy),      32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
